// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the CPU RAM strobe interface.
// A request is captured in IDLE, held in BUSY for WAIT_STATES extra cycles,
// and then performed on the internal word array. The result is reported
// with a four-phase ready handshake in DONE.
// Optional feature macro: RAM_PROTECT_EN. When it is defined, a write to an
// address below PROT_LIMIT completes normally but leaves memory unchanged
// and pulses err in the same cycle that ready rises.
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1,
    parameter int PROT_LIMIT  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RAMenable,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    // The limit is widened by one bit so that PROT_LIMIT = 2^ADDR_WIDTH
    // still compares correctly against every address.
    localparam logic [ADDR_WIDTH:0] PROT_LIMIT_W = (ADDR_WIDTH + 1)'(PROT_LIMIT);
`ifdef RAM_PROTECT_EN
    localparam logic PROTECT_ON = 1'b1;
`else
    localparam logic PROTECT_ON = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r,    state_s;
    logic [3:0]            cnt_r,      cnt_s;
    logic [ADDR_WIDTH-1:0] addr_r,     addr_s;
    logic [DATA_WIDTH-1:0] data_r,     data_s;
    logic                  is_write_r, is_write_s;
    logic                  ready_r,    ready_s;
    logic                  err_r,      err_s;
    logic [DATA_WIDTH-1:0] dout_r,     dout_s;
    logic                  mem_we_s;
    logic                  prot_hit_s;

    // The latched address falls inside the write-protected window.
    assign prot_hit_s = PROTECT_ON && ({1'b0, addr_r} < PROT_LIMIT_W);

    // Next-state logic, request capture and access decision for the handshake FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        data_s     = data_r;
        is_write_s = is_write_r;
        ready_s    = ready_r;
        err_s      = 1'b0;
        dout_s     = dout_r;
        mem_we_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (RAMenable && read && write) begin
                    // Both strobes are set: flag the request every cycle it persists and stay idle.
                    err_s = 1'b1;
                end else if (RAMenable && (read ^ write)) begin
                    addr_s     = addr;
                    data_s     = data_in;
                    is_write_s = write;
                    cnt_s      = WAIT_LOAD;
                    state_s    = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    ready_s = 1'b1;
                    state_s = DONE;
                    if (is_write_r) begin
                        if (prot_hit_s) begin
                            err_s = 1'b1;
                        end else begin
                            mem_we_s = 1'b1;
                        end
                    end else begin
                        dout_s = mem_r[addr_r];
                    end
                end
            end
            DONE: begin
                if (!RAMenable) begin
                    ready_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    ready_s = 1'b1;
                end
            end
            default: begin
                ready_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Control and output registers; a reset during BUSY abandons the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            data_r     <= '0;
            is_write_r <= 1'b0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            dout_r     <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            is_write_r <= is_write_s;
            ready_r    <= ready_s;
            err_r      <= err_s;
            dout_r     <= dout_s;
        end
    end

    // Word array write port; the contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= data_r;
        end
    end

    assign data_out = dout_r;
    assign ready    = ready_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ram_responder.sv
// Testbench for ram_responder. Two instances are driven by the same
// initiator: one with WAIT_STATES=1 and one with WAIT_STATES=0. Each
// observed output is compared, cycle by cycle, with values derived from the
// latency rule (ready after edge k+1+W), a flat memory model, and the
// protection rule.
`timescale 1ns/1ps
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        RAMenable, read, write;
    logic [8:0]  addr;
    logic [31:0] data_in;
    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, err0, err1;

`ifdef RAM_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [512];
    bit          known [512];
    int          known_list [$];
    logic [31:0] exp_prev;

    ram_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(1), .PROT_LIMIT(64)) dut1 (
        .clk(clk), .reset(reset), .RAMenable(RAMenable), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(dout1), .ready(rdy1), .err(err1));

    ram_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0), .PROT_LIMIT(64)) dut0 (
        .clk(clk), .reset(reset), .RAMenable(RAMenable), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(dout0), .ready(rdy0), .err(err0));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete handshake. hold = extra cycles RAMenable stays high after
    // the slower ready rises; early = drop RAMenable right after capture.
    task automatic do_req(input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                          input int hold, input bit early);
        int          drop_c, last_c;
        bit          prot;
        logic [31:0] rd_val;
        prot   = PROT_ON && is_wr && (a < 9'd64);
        rd_val = model_mem[a];
        drop_c = early ? 0 : 2 + hold;
        last_c = early ? 3 : drop_c + 1;
        @(negedge clk);
        RAMenable = 1'b1; read = !is_wr; write = is_wr; addr = a; data_in = d;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            for (int w = 0; w < 2; w++) begin
                bit          e_rdy, e_err;
                logic [31:0] e_dout;
                e_rdy  = (c >= 1 + w) && (c <= drop_c || c == 1 + w);
                e_err  = prot && (c == 1 + w);
                e_dout = (c >= 1 + w && !is_wr) ? rd_val : exp_prev;
                check_eq($sformatf("ready_w%0d_c%0d", w, c), {31'd0, (w == 0) ? rdy0 : rdy1}, {31'd0, e_rdy});
                check_eq($sformatf("err_w%0d_c%0d", w, c), {31'd0, (w == 0) ? err0 : err1}, {31'd0, e_err});
                check_eq($sformatf("dout_w%0d_c%0d_a%0h", w, c, a), (w == 0) ? dout0 : dout1, e_dout);
            end
            @(negedge clk);
            if (c >= drop_c) RAMenable = 1'b0;
            read = 1'($urandom); write = 1'($urandom);
            addr = 9'($urandom); data_in = $urandom;
        end
        if (is_wr && !prot) begin
            model_mem[a] = d;
            if (!known[a]) begin
                known[a] = 1'b1;
                known_list.push_back(int'(a));
            end
        end
        if (!is_wr) exp_prev = rd_val;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; RAMenable = 1'b0; read = 1'b0; write = 1'b0;
        addr = 9'd0; data_in = 32'd0; exp_prev = 32'd0;
        for (int i = 0; i < 512; i++) begin
            model_mem[i] = 32'd0;
            known[i] = 1'b0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {30'd0, rdy1, rdy0}, 32'd0);
        check_eq("rst_err", {30'd0, err1, err0}, 32'd0);
        check_eq("rst_dout1", dout1, 32'd0);
        check_eq("rst_dout0", dout0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed: write/read 0x0A0 and the top word 0x1FF.
        do_req(1'b1, 9'h0A0, 32'h12345678, 0, 1'b0);
        do_req(1'b0, 9'h0A0, 32'h0, 0, 1'b0);
        do_req(1'b1, 9'h1FF, 32'hCAFEF00D, 1, 1'b0);
        do_req(1'b0, 9'h1FF, 32'h0, 5, 1'b0);
        // Dropping RAMenable in BUSY still completes the access.
        do_req(1'b0, 9'h0A0, 32'h0, 0, 1'b1);

        // Illegal request: both strobes for 2 cycles, then neither strobe.
        @(negedge clk);
        RAMenable = 1'b1; read = 1'b1; write = 1'b1; addr = 9'h0A0; data_in = 32'hBADBAD00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("ill_err_%0d", i), {30'd0, err1, err0}, 32'h3);
            check_eq($sformatf("ill_rdy_%0d", i), {30'd0, rdy1, rdy0}, 32'd0);
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        check_eq("nostrobe_err", {30'd0, err1, err0}, 32'd0);
        check_eq("nostrobe_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        check_eq("ill_dout", dout1, exp_prev);
        @(negedge clk);
        RAMenable = 1'b0;
        do_req(1'b0, 9'h0A0, 32'h0, 0, 1'b0);

        // Reset in the middle of a write: nothing is committed and the outputs clear.
        do_req(1'b1, 9'h080, 32'h11112222, 0, 1'b0);
        @(negedge clk);
        RAMenable = 1'b1; write = 1'b1; read = 1'b0; addr = 9'h080; data_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        check_eq("rstw_cap_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rstw_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        check_eq("rstw_err", {30'd0, err1, err0}, 32'd0);
        check_eq("rstw_dout1", dout1, 32'd0);
        check_eq("rstw_dout0", dout0, 32'd0);
        exp_prev = 32'd0;
        @(negedge clk);
        RAMenable = 1'b0; write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_req(1'b0, 9'h080, 32'h0, 0, 1'b0);

        // Protected window boundary: 0x010 is protected, 0x040 is writable.
        do_req(1'b1, 9'h010, 32'hFFFFFFFF, 0, 1'b0);
        do_req(1'b1, 9'h040, 32'h0BADC0DE, 0, 1'b0);
        do_req(1'b0, 9'h040, 32'h0, 0, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            logic [8:0]  a;
            wr = (known_list.size() == 0) || ($urandom_range(0, 1) == 0);
            if (wr) begin
                a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 63)) : 9'($urandom);
            end else begin
                a = 9'(known_list[$urandom_range(0, known_list.size() - 1)]);
            end
            do_req(wr, a, $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the CPU's RAM strobe interface. The control unit drives `RAMenable`, `read` and `write` together with the MAR address and MDR data. This block samples each request, inserts a configurable number of wait states, performs the access on its internal word array and returns `ready` with read data under a four-phase handshake. It sits between MAR/MDR and the bus, replacing the zero-latency RAM model.

## Interface
- `ADDR_WIDTH`, default 9: word-address width; the array holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width.
- `WAIT_STATES`, default 1: extra cycles between request capture and completion (0–15).
- `PROT_LIMIT`, default 64: first writable address. Used only with `RAM_PROTECT_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `RAMenable`  in  1  request valid, held by the initiator until `ready` is seen.
- `read`  in  1  read strobe, qualified by `RAMenable`.
- `write`  in  1  write strobe, qualified by `RAMenable`.
- `addr`  in  ADDR_WIDTH  word address (MAR).
- `data_in`  in  DATA_WIDTH  write data (MDR).
- `data_out`  out  DATA_WIDTH  read data, registered.
- `ready`  out  1  access complete, held until `RAMenable` falls.
- `err`  out  1  one-cycle pulse on an illegal request (both strobes set, or a protected write).

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** a request is taken at the first edge where `RAMenable=1` and exactly one of `read`/`write` is 1.
  - The block latches `addr`, `data_in` and the operation, loads `cnt=WAIT_STATES`, and moves to BUSY.
- **Illegal request in IDLE:** `RAMenable=1` with `read=write=1` produces an `err` pulse for one cycle. The state stays IDLE and memory is untouched.
  - The condition is re-flagged every cycle it persists.
- **`RAMenable=1` with neither strobe set:** ignored, no `err`.
- **BUSY:** if `cnt≠0`, decrement. If `cnt=0`, perform the access and go to DONE with `ready=1`.
  - Read: `data_out ← mem[addr_latched]`.
  - Write: `mem[addr_latched] ← data_latched`.
- **DONE:** `ready` stays at 1 while `RAMenable=1`. On the first edge with `RAMenable=0`, `ready←0` and the state returns to IDLE.
  - A new request cannot be accepted before IDLE, so back-to-back requests require a deasserted gap.
- **Inputs ignored outside IDLE:** changes to `addr`, `data_in` or the strobes while in BUSY/DONE do not affect the access in progress.
- **Dropping `RAMenable` in BUSY:** the access still completes. DONE is then exited on the next edge, so `ready` is high for one cycle.
- **Address range:** `addr` is the full index and cannot go out of range; there is no wrap logic.
- **`data_out` on write:** holds its previous value on writes.

## Timing
- **Reset (async, `reset=0`):** state=IDLE, `cnt=0`, `ready=0`, `err=0`, `data_out=0`.
  - Memory contents are not cleared.
  - A write interrupted in BUSY by reset is not committed.
- **Latency:** request sampled at edge k → `ready` and `data_out` valid after edge k+1+WAIT_STATES.
  - The write commits at that same edge.
  - WAIT_STATES=0 gives a 1-cycle turnaround.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Control-unit timing:** the control unit changes strobes on the falling edge, so inputs are stable at every rising edge.
- **`err`:** asserted for exactly one cycle per offending sample.
- **Handshake:** minimum request-to-request spacing is WAIT_STATES+3 cycles: capture, wait states, DONE, and one IDLE cycle at `RAMenable=0`.

## Configuration
- **`RAM_PROTECT_EN` defined:** a write with latched address < `PROT_LIMIT` is still accepted and goes through BUSY/DONE normally, but has two differences at completion:
  - Memory is left unchanged.
  - `err` pulses in the same cycle `ready` rises.
  - Reads are unaffected.
- **Not defined:** all addresses are writable, `PROT_LIMIT` is unused, and `err` flags only the both-strobes case.

## Test plan
- Reset with `reset=0` mid-BUSY on a write of `0xDEADBEEF` to 0x80 → `ready=0` and `data_out=0` immediately; a later read of 0x80 returns its prior value.
- WAIT_STATES=1, write `0x12345678` to 0x0A0, then read 0x0A0 → each `ready` rises 2 edges after capture; read returns `0x12345678`.
- WAIT_STATES=0, read from 0x1FF (top word, preloaded `0xCAFEF00D`) → `ready` one edge after capture, `data_out=0xCAFEF00D`.
- Hold `RAMenable=1` for 5 cycles after `ready` → `ready` stays 1 and no second access occurs; dropping `RAMenable` clears `ready` at the next edge.
- `RAMenable=1`, `read=write=1` for 2 cycles → `err` high 2 cycles, `ready` never asserts, memory unchanged.
- `RAM_PROTECT_EN`, `PROT_LIMIT=64`: write `0xFFFFFFFF` to 0x010 → `ready` and `err` pulse together; a read of 0x010 returns the old value. A write to 0x040 succeeds with no `err`.
